parity_serial_tx: RTL
=====================

// Module: parity_serial_tx
// PURPOSE
//   Serial frame transmitter built around the 4-bit parity generator's function.
//   Accepts a parallel word over a valid/ready handshake and drives a 1-bit line:
//   start bit, DATA_W data bits LSB first, one parity bit (even/odd per word), stop bit.
//   Parity is accumulated one bit per data slot; this block is the controller that
//   sequences parity generation for words wider than the 4-bit combinational generator.
// PARAMETERS
//   DATA_W      8   data bits per frame (>=1)
//   BIT_CYCLES  4   clk cycles each line bit is held (>=1; 1 = one bit per clk)
// PORTS
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous reset, active high
//   in_data   in   DATA_W  word to send, sampled on accept
//   in_valid  in   1       word available
//   odd_sel   in   1       0 = even parity, 1 = odd parity; sampled on accept
//   in_ready  out  1       block can accept (combinational: state==IDLE && !rst)
//   tx        out  1       serial line, registered, idles high
//   busy      out  1       registered, high from cycle after accept to end of stop bit
//   done      out  1       registered one-cycle pulse, last cycle of stop bit
// BEHAVIOUR
//   Reset (rst high at clk edge): state=IDLE, tx=1, busy=0, done=0, counters=0,
//     parity accumulator=0. rst overrides every other input; in_ready=0 while rst=1.
//   Accept: in_valid && in_ready at an edge -> latch in_data into shift reg,
//     latch odd_sel, parity acc<=0; next cycle state=START, tx=0, busy=1.
//   in_valid while busy is ignored; in_data/odd_sel changes after accept have no effect.
//   FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//     Each non-IDLE state holds its tx value for exactly BIT_CYCLES cycles,
//     counted by cyc_cnt (width clog2(BIT_CYCLES), min 1); advance when
//     cyc_cnt==BIT_CYCLES-1, cyc_cnt wraps to 0.
//     START : tx=0.
//     DATA  : tx=shift[0]; at end of each slot shift>>=1, acc^=bit sent,
//             bit_cnt++ (width clog2(DATA_W), min 1); after bit DATA_W-1 -> PARITY.
//     PARITY: tx = acc ^ odd_sel_q (total ones incl. parity: even if odd_sel=0,
//             odd if odd_sel=1).
//     STOP  : tx=1; done=1 in its final cycle; next cycle IDLE, busy=0.
//   Frame length: (DATA_W+3)*BIT_CYCLES cycles of busy=1.
//   Back-to-back: in_ready rises in first IDLE cycle after done; accept possible
//     there, giving exactly one tx=1 idle cycle between frames.
//   IDLE: tx=1, busy=0, done=0.
//   Reset mid-frame: frame abandoned, tx=1 next cycle, no done pulse, no resume.
//   DATA_W=1, BIT_CYCLES=1 must work (no zero-width counters, no off-by-one).
// TESTING (DATA_W=8, BIT_CYCLES=4 unless stated)
//   1 Reset held 3 cycles -> tx=1, busy=0, done=0, in_ready=0; after release in_ready=1.
//   2 in_data=8'hA5, odd_sel=0 -> tx bits 0,1,0,1,0,0,1,0,1,0,1 each 4 cycles;
//     busy=1 for 44 cycles; done pulses once on cycle 44.
//   3 in_data=8'h07: odd_sel=1 -> parity bit 0; odd_sel=0 -> parity bit 1;
//     8'h00 odd_sel=1 -> parity 1.
//   4 in_valid held high with 8'hFF then 8'h01 -> two frames, one idle tx=1
//     cycle between; in_valid pulses during busy produce no extra frame.
//   5 rst asserted during DATA bit 3 of 8'hA5 -> tx=1, busy=0 next cycle, no done;
//     next accepted word transmits a complete, correct frame.
//   6 BIT_CYCLES=1, DATA_W=1: in_data=1, odd_sel=0 -> tx 0,1,1,1 on consecutive
//     cycles; done on 4th cycle.

Source files
------------

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, even/odd parity, stop bit.
// Parity is accumulated one data bit per slot, so the word width is not limited by a wide XOR tree.
module parity_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              odd_sel,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [CYC_W-1:0]    r_cyc;
  logic [BIT_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_acc;
  logic                r_odd;
  logic                r_tx;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_next;
  logic [CYC_W-1:0]    w_cyc_next;
  logic [BIT_W-1:0]    w_bit_next;
  logic [DATA_W-1:0]   w_shift_next;
  logic                w_acc_next;
  logic                w_odd_next;
  logic                w_slot_end;
  logic                w_tx_next;
  logic                w_busy_next;
  logic                w_done_next;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign w_slot_end = (r_cyc == CYC_LAST);
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_acc   <= 1'b0;
      r_odd   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cyc   <= w_cyc_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_acc   <= w_acc_next;
      r_odd   <= w_odd_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cyc_next   = r_cyc;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_acc_next   = r_acc;
    w_odd_next   = r_odd;
    if (r_state != S_IDLE) begin
      w_cyc_next = w_slot_end ? '0 : r_cyc + CYC_W'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_state_next = S_START;
          w_shift_next = in_data;
          w_odd_next   = odd_sel;
          w_acc_next   = 1'b0;
          w_bit_next   = '0;
          w_cyc_next   = '0;
        end
      end
      S_START: begin
        if (w_slot_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        // Fold the bit just sent into the parity before shifting it out.
        if (w_slot_end) begin
          w_shift_next = r_shift >> 1;
          w_acc_next   = r_acc ^ r_shift[0];
          if (r_bit == BIT_LAST) begin
            w_bit_next   = '0;
            w_state_next = S_PARITY;
          end else begin
            w_bit_next = r_bit + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_slot_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_slot_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line outputs are registered, so they are decoded from the upcoming state.
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = (w_state_next != S_IDLE);
    w_done_next = (w_state_next == S_STOP) && (w_cyc_next == CYC_LAST);
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = w_acc_next ^ w_odd_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

endmodule
